// File: rtl/nmea_speed_parser.sv
// rtl/nmea_speed_parser.sv - NMEA VTG sentence parser publishing checksum-verified km/h ground speed
module nmea_speed_parser #(
  parameter int max_speed_p = 99
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [7:0] rx_data_i,
  input  logic       rx_valid_i,
  output logic [7:0] speed_o,
  output logic       speed_valid_o,
  output logic       csum_err_o
);

  localparam logic [7:0] MaxSpeed = 8'(max_speed_p);
  localparam logic [7:0] ChDollar = 8'h24;
  localparam logic [7:0] ChStar   = 8'h2A;
  localparam logic [7:0] ChComma  = 8'h2C;
  localparam logic [7:0] ChDot    = 8'h2E;
  localparam logic [7:0] ChCr     = 8'h0D;
  localparam logic [7:0] ChLf     = 8'h0A;

  typedef enum logic [2:0] {IDLE, HDR, BODY, CS_HI, CS_LO} state_t;

  state_t      state_q, state_d;
  logic [7:0]  xor_q, xor_d;
  logic [2:0]  hdr_idx_q, hdr_idx_d;
  logic [3:0]  comma_q, comma_d;
  logic [7:0]  acc_q, acc_d;
  logic        frac_q, frac_d;
  logic        have_q, have_d;
  logic [3:0]  cs_hi_q, cs_hi_d;
  logic [7:0]  speed_q, speed_d;
  logic        speed_valid_q, speed_valid_d;
  logic        csum_err_q, csum_err_d;

  logic        is_digit, is_hex, hdr_match, is_eol;
  logic [3:0]  hex_val;
  logic [11:0] acc_wide;

  // Character classification: digit/hex decode, header expectation, line ends
  always_comb begin
    is_digit = (rx_data_i >= 8'h30) && (rx_data_i <= 8'h39);
    is_hex   = is_digit;
    hex_val  = rx_data_i[3:0];
    if (((rx_data_i >= 8'h41) && (rx_data_i <= 8'h46)) ||
        ((rx_data_i >= 8'h61) && (rx_data_i <= 8'h66))) begin
      is_hex  = 1'b1;
      hex_val = rx_data_i[3:0] + 4'd9;
    end
    is_eol = (rx_data_i == ChCr) || (rx_data_i == ChLf);
    case (hdr_idx_q)
      3'd0:    hdr_match = (rx_data_i == 8'h47);
      3'd1:    hdr_match = (rx_data_i == 8'h50) || (rx_data_i == 8'h4E);
      3'd2:    hdr_match = (rx_data_i == 8'h56);
      3'd3:    hdr_match = (rx_data_i == 8'h54);
      3'd4:    hdr_match = (rx_data_i == 8'h47);
      default: hdr_match = 1'b0;
    endcase
    // Wide enough that a saturated 255 accumulator cannot wrap before clamping
    acc_wide = ({4'd0, acc_q} * 12'd10) + {8'd0, rx_data_i[3:0]};
  end

  // Sentence FSM, field extraction and completion decision
  always_comb begin
    state_d       = state_q;
    xor_d         = xor_q;
    hdr_idx_d     = hdr_idx_q;
    comma_d       = comma_q;
    acc_d         = acc_q;
    frac_d        = frac_q;
    have_d        = have_q;
    cs_hi_d       = cs_hi_q;
    speed_d       = speed_q;
    speed_valid_d = 1'b0;
    csum_err_d    = 1'b0;
    if (rx_valid_i) begin
      if (rx_data_i == ChDollar) begin
        // Start of sentence in any state, including resync mid-sentence
        state_d   = HDR;
        xor_d     = 8'd0;
        hdr_idx_d = 3'd0;
        comma_d   = 4'd0;
        acc_d     = 8'd0;
        frac_d    = 1'b0;
        have_d    = 1'b0;
      end else begin
        case (state_q)
          IDLE: ;
          HDR: begin
            if (hdr_match) begin
              xor_d = xor_q ^ rx_data_i;
              if (hdr_idx_q == 3'd4) state_d = BODY;
              else                   hdr_idx_d = hdr_idx_q + 3'd1;
            end else begin
              state_d = IDLE;
            end
          end
          BODY: begin
            if (is_eol) begin
              state_d = IDLE;
            end else if (rx_data_i == ChStar) begin
              state_d = CS_HI;
            end else begin
              xor_d = xor_q ^ rx_data_i;
              if (rx_data_i == ChComma) begin
                if (comma_q != 4'd15) comma_d = comma_q + 4'd1;
              end else if (comma_q == 4'd7) begin
                if (is_digit) begin
                  have_d = 1'b1;
                  if (!frac_q) acc_d = (acc_wide > 12'd255) ? 8'd255 : acc_wide[7:0];
                end else if (rx_data_i == ChDot) begin
                  frac_d = 1'b1;
                end
              end
            end
          end
          CS_HI: begin
            if (is_hex) begin
              cs_hi_d = hex_val;
              state_d = CS_LO;
            end else begin
              state_d = IDLE;
            end
          end
          CS_LO: begin
            state_d = IDLE;
            if (is_hex) begin
              if ({cs_hi_q, hex_val} == xor_q) begin
                if (have_q) begin
                  speed_d       = (acc_q > MaxSpeed) ? MaxSpeed : acc_q;
                  speed_valid_d = 1'b1;
                end
              end else begin
                csum_err_d = 1'b1;
              end
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q       <= IDLE;
      xor_q         <= 8'd0;
      hdr_idx_q     <= 3'd0;
      comma_q       <= 4'd0;
      acc_q         <= 8'd0;
      frac_q        <= 1'b0;
      have_q        <= 1'b0;
      cs_hi_q       <= 4'd0;
      speed_q       <= 8'd0;
      speed_valid_q <= 1'b0;
      csum_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      xor_q         <= xor_d;
      hdr_idx_q     <= hdr_idx_d;
      comma_q       <= comma_d;
      acc_q         <= acc_d;
      frac_q        <= frac_d;
      have_q        <= have_d;
      cs_hi_q       <= cs_hi_d;
      speed_q       <= speed_d;
      speed_valid_q <= speed_valid_d;
      csum_err_q    <= csum_err_d;
    end
  end

  assign speed_o       = speed_q;
  assign speed_valid_o = speed_valid_q;
  assign csum_err_o    = csum_err_q;

endmodule

// File: tb/tb_nmea_speed_parser.sv
// tb/tb_nmea_speed_parser.sv - scoreboard bench for nmea_speed_parser
module tb_nmea_speed_parser;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic [7:0] rx_data_i;
  logic       rx_valid_i;
  logic [7:0] speed_o;
  logic       speed_valid_o;
  logic       csum_err_o;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    bit         is_err;
    logic [7:0] speed;
    int         cyc;
  } exp_t;

  exp_t sb[$];

  nmea_speed_parser #(.max_speed_p(99)) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .rx_data_i     (rx_data_i),
    .rx_valid_i    (rx_valid_i),
    .speed_o       (speed_o),
    .speed_valid_o (speed_valid_o),
    .csum_err_o    (csum_err_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    rx_valid_i = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  // Called right after the last checksum byte was consumed
  task automatic expect_evt(input bit is_err, input logic [7:0] spd);
    exp_t e;
    e.is_err = is_err;
    e.speed  = spd;
    e.cyc    = cyc;
    sb.push_back(e);
  endtask

  // Monitor: every output pulse is matched against the scoreboard head
  always @(negedge clk_i) begin
    if (reset_i === 1'b1 && (speed_valid_o || csum_err_o)) begin
      check("pulse_exclusive", int'(speed_valid_o && csum_err_o), 0);
      if (sb.size() == 0) begin
        check("unexpected_pulse", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pulse_kind_err", int'(csum_err_o), int'(e.is_err));
        check("speed_value", int'(speed_o), int'(e.speed));
        check("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i    = 1'b0;
    rx_valid_i = 1'b0;
    rx_data_i  = 8'h00;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_speed", int'(speed_o), 0);
    check("reset_valid", int'(speed_valid_o), 0);
    check("reset_err", int'(csum_err_o), 0);
    reset_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;

    // Plain good sentence
    send_str("$GPVTG,,,,,,,42,K*1F");
    expect_evt(1'b0, 8'd42);
    send_str("\r\n");

    // GN talker, fractional part truncated, clamped to ceiling
    send_str("$GNVTG,,,,,,,123.9,K*20");
    expect_evt(1'b0, 8'd99);
    send_str("\r\n");

    // Accumulator must saturate rather than wrap (256 would wrap to 0)
    send_str("$GPVTG,,,,,,,256,K*28");
    expect_evt(1'b0, 8'd99);
    send_str("\r\n");

    // Restore 42, then a bad checksum must keep it
    send_str("$GPVTG,,,,,,,42,K*1F");
    expect_evt(1'b0, 8'd42);
    send_str("$GPVTG,,,,,,,42,K*20");
    expect_evt(1'b1, 8'd42);
    send_str("\r\n");

    // Empty speed field with good checksum: silent
    send_str("$GPVTG,,,,,,,,K*19\r\n");

    // Non-VTG ignored, restart on '$' resyncs, lowercase hex accepted
    send_str("$GPRMC,1,2*4A\r\n");
    send_str("$GPV$GPVTG,,,,,,,42,K*1f");
    expect_evt(1'b0, 8'd42);
    send_str("\r\n");

    repeat (3) @(posedge clk_i);
    #1;
    check("speed_held", int'(speed_o), 42);

    // Asynchronous reset mid-sentence
    send_str("$GPVTG,,,,,,,4");
    #2;
    reset_i = 1'b0;
    #1;
    check("async_reset_speed", int'(speed_o), 0);
    @(posedge clk_i);
    #1;
    reset_i = 1'b1;
    send_str("2,K*1F\r\n");
    check("post_reset_speed", int'(speed_o), 0);
    send_str("$GPVTG,,,,,,,42,K*1F");
    expect_evt(1'b0, 8'd42);
    send_str("\r\n");

    repeat (5) @(posedge clk_i);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
